data_sram_resp: RTL and testbench



---
 rtl/data_sram_resp_pkg.sv | 25 ++
 rtl/dsram_wbuf.sv | 32 +++
 rtl/data_sram_resp.sv | 159 +++++++++++++++
 tb/tb_data_sram_resp.sv | 384 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_sram_resp_pkg.sv
// Shared types for the data SRAM responder: FSM states, stall encoding and the
// buffered-store record.
package data_sram_resp_pkg;

  typedef enum logic [1:0] {
    DsIdle   = 2'd0,
    DsRdReq  = 2'd1,
    DsRdDone = 2'd2,
    DsWbReq  = 2'd3
  } ds_state_e;

  localparam logic Stop   = 1'b1;
  localparam logic NoStop = 1'b0;

  typedef struct packed {
    logic [31:0] addr;   // word aligned
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } store_t;

  function automatic logic [31:0] word_addr(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/dsram_wbuf.sv
// One-entry posted-store buffer with a same-word compare against the
// currently presented request address.
module dsram_wbuf
  import data_sram_resp_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        load,
  input  logic        clear,
  input  store_t      din,
  input  logic [31:0] cmp_addr,
  output logic        valid,
  output store_t      dout,
  output logic        hit
);

  // capture a store on load, drop it once the bus has acknowledged it
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid <= 1'b0;
      dout  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      dout  <= din;
    end else if (clear) begin
      valid <= 1'b0;
    end
  end

  assign hit = valid && (dout.addr[31:2] == cmp_addr[31:2]);

endmodule

// File: rtl/data_sram_resp.sv
// Data SRAM responder: turns single-cycle EX-stage SRAM requests into a
// req/ack bus transaction, posts stores through a one-entry buffer and holds
// the pipeline with stallreq_for_mem until each request can complete.
module data_sram_resp
  import data_sram_resp_pkg::*;
#(
  parameter bit WBUF_EN = 1'b1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic        stallreq_for_mem,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        wbuf_busy
);

  ds_state_e   state, state_nxt;
  store_t      req_st, buf_q, wb_st;
  logic        is_store, ack, buf_valid, buf_hit;
  logic        accept, buf_load, buf_clear, issue_rd, issue_wb, wb_from_req, own_set;
  logic        own_q;
  logic [31:0] rd_q;

  assign is_store = |data_sram_wen;
  // an ack with no request outstanding is ignored
  assign ack      = mem_req & mem_ack;
  assign req_st   = {word_addr(data_sram_addr), data_sram_wen, data_sram_wdata};
  assign wb_st    = wb_from_req ? req_st : buf_q;

  dsram_wbuf u_wbuf (
    .clk      (clk),
    .resetn   (resetn),
    .load     (buf_load),
    .clear    (buf_clear),
    .din      (req_st),
    .cmp_addr (data_sram_addr),
    .valid    (buf_valid),
    .dout     (buf_q),
    .hit      (buf_hit)
  );

  // FSM state register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= DsIdle;
    else         state <= state_nxt;
  end

  // next state, acceptance and bus-issue decisions
  always_comb begin
    state_nxt   = state;
    accept      = 1'b0;
    buf_load    = 1'b0;
    buf_clear   = 1'b0;
    issue_rd    = 1'b0;
    issue_wb    = 1'b0;
    wb_from_req = 1'b0;
    own_set     = 1'b0;
    case (state)
      DsIdle: begin
        if (data_sram_en && !is_store) begin
          // a pending store to the same word must land before the read
          if (buf_hit) begin
            issue_wb  = 1'b1;
            state_nxt = DsWbReq;
          end else begin
            issue_rd  = 1'b1;
            state_nxt = DsRdReq;
          end
        end else if (data_sram_en) begin
          if (buf_valid) begin
            issue_wb  = 1'b1;
            state_nxt = DsWbReq;
          end else if (WBUF_EN) begin
            accept   = 1'b1;
            buf_load = 1'b1;
          end else begin
            // unbuffered: the store itself goes to the bus and stays stalled
            buf_load    = 1'b1;
            issue_wb    = 1'b1;
            wb_from_req = 1'b1;
            own_set     = 1'b1;
            state_nxt   = DsWbReq;
          end
        end else if (buf_valid) begin
          issue_wb  = 1'b1;
          state_nxt = DsWbReq;
        end
      end
      DsRdReq: if (ack) state_nxt = DsRdDone;
      DsRdDone: begin
        accept    = 1'b1;
        state_nxt = DsIdle;
      end
      DsWbReq: if (ack) begin
        buf_clear = 1'b1;
        accept    = own_q;
        state_nxt = DsIdle;
      end
      default: state_nxt = DsIdle;
    endcase
  end

  assign stallreq_for_mem = (resetn && data_sram_en && !accept) ? Stop : NoStop;
  assign wbuf_busy        = buf_valid;

  // remember that the buffered store is the one the pipeline is stalled on
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)        own_q <= 1'b0;
    else if (own_set)   own_q <= 1'b1;
    else if (buf_clear) own_q <= 1'b0;
  end

  // registered bus request, held stable until its ack
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_wstrb <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else if (issue_rd) begin
      mem_req   <= 1'b1;
      mem_we    <= 1'b0;
      mem_wstrb <= '0;
      mem_addr  <= word_addr(data_sram_addr);
      mem_wdata <= '0;
    end else if (issue_wb) begin
      mem_req   <= 1'b1;
      mem_we    <= 1'b1;
      mem_wstrb <= wb_st.wstrb;
      mem_addr  <= wb_st.addr;
      mem_wdata <= wb_st.wdata;
    end else if (ack) begin
      mem_req   <= 1'b0;
    end
  end

  // read data: captured on ack, handed to MEM when the load is accepted
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_q            <= '0;
      data_sram_rdata <= '0;
    end else begin
      if (state == DsRdReq && ack) rd_q <= mem_rdata;
      if (state == DsRdDone)       data_sram_rdata <= rd_q;
    end
  end

endmodule

// File: tb/tb_data_sram_resp.sv
// Bench for data_sram_resp: a latency-randomised memory responder applies bus
// writes to a word-addressed memory; an architectural memory updated in
// program order at request acceptance predicts every load result, which a
// monitor compares when the DUT returns it. Directed cases cover latency,
// ordering, unbuffered mode and reset.
module tb_data_sram_resp;

  logic clk = 1'b0;
  logic resetn = 1'b1;
  always #5 clk = ~clk;

  // buffered instance
  logic        data_sram_en = 1'b0;
  logic [3:0]  data_sram_wen = '0;
  logic [31:0] data_sram_addr = '0, data_sram_wdata = '0;
  logic [31:0] data_sram_rdata;
  logic        stallreq_for_mem, mem_req, mem_we, wbuf_busy;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;

  // unbuffered instance
  logic        u1_en = 1'b0;
  logic [3:0]  u1_wen = '0;
  logic [31:0] u1_addr = '0, u1_wdata = '0;
  logic [31:0] u1_rdata;
  logic        u1_stall, u1_req, u1_we, u1_busy;
  logic [3:0]  u1_wstrb;
  logic [31:0] u1_maddr, u1_mwdata;
  logic        u1_ack = 1'b0;
  logic [31:0] u1_mrdata = '0;

  data_sram_resp #(.WBUF_EN(1'b1)) dut (
    .clk(clk), .resetn(resetn),
    .data_sram_en(data_sram_en), .data_sram_wen(data_sram_wen),
    .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
    .data_sram_rdata(data_sram_rdata), .stallreq_for_mem(stallreq_for_mem),
    .mem_req(mem_req), .mem_we(mem_we), .mem_wstrb(mem_wstrb),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .wbuf_busy(wbuf_busy)
  );

  data_sram_resp #(.WBUF_EN(1'b0)) dut_nobuf (
    .clk(clk), .resetn(resetn),
    .data_sram_en(u1_en), .data_sram_wen(u1_wen),
    .data_sram_addr(u1_addr), .data_sram_wdata(u1_wdata),
    .data_sram_rdata(u1_rdata), .stallreq_for_mem(u1_stall),
    .mem_req(u1_req), .mem_we(u1_we), .mem_wstrb(u1_wstrb),
    .mem_addr(u1_maddr), .mem_wdata(u1_mwdata),
    .mem_ack(u1_ack), .mem_rdata(u1_mrdata), .wbuf_busy(u1_busy)
  );

  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out", name);
  endtask

  // ---------------- memory models ----------------
  logic [31:0] bus_mem  [int];
  logic [31:0] arch_mem [int];

  function automatic int widx(input logic [31:0] a);
    return int'(a[31:2]);
  endfunction
  function automatic logic [31:0] init_word(input int w);
    return 32'hA5A5_0000 ^ 32'(w);
  endfunction
  function automatic logic [31:0] bus_rd(input int w);
    return bus_mem.exists(w) ? bus_mem[w] : init_word(w);
  endfunction
  function automatic logic [31:0] arch_rd(input int w);
    return arch_mem.exists(w) ? arch_mem[w] : init_word(w);
  endfunction
  function automatic logic [31:0] merge(input logic [31:0] old, input logic [3:0] st,
                                        input logic [31:0] d);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (st[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } txn_t;
  txn_t bus_log[$];

  // ---------------- bus responder (buffered instance) ----------------
  int fixed_lat = 0;
  bit resp_en = 1'b1;
  bit inject_ack = 1'b0;

  initial begin : responder
    bit   busy;
    int   cnt, lat;
    txn_t cur;
    busy = 1'b0; cnt = 0; lat = 1;
    cur = '{1'b0, 32'h0, 4'h0, 32'h0};
    forever begin
      @(posedge clk); #1;
      if (!resp_en) begin
        busy = 1'b0;
        mem_ack = inject_ack;
        continue;
      end
      if (mem_ack) begin
        mem_ack = 1'b0;
        busy = 1'b0;
        chk("req_drop_after_ack", {31'b0, mem_req}, 32'd0);
      end else if (mem_req) begin
        if (!busy) begin
          busy = 1'b1;
          cnt  = 0;
          lat  = (fixed_lat > 0) ? fixed_lat : int'($urandom_range(1, 4));
          cur  = '{mem_we, mem_addr, mem_wstrb, mem_wdata};
          bus_log.push_back(cur);
          chk("bus_addr_aligned", {30'b0, mem_addr[1:0]}, 32'd0);
        end else begin
          chk("bus_addr_stable", mem_addr, cur.addr);
          chk("bus_ctrl_stable", {27'b0, mem_we, mem_wstrb}, {27'b0, cur.we, cur.wstrb});
          chk("bus_wdata_stable", mem_wdata, cur.wdata);
        end
        cnt++;
        if (cnt == lat) begin
          mem_ack = 1'b1;
          if (cur.we) bus_mem[widx(cur.addr)] = merge(bus_rd(widx(cur.addr)), cur.wstrb, cur.wdata);
          else        mem_rdata = bus_rd(widx(cur.addr));
        end
      end
    end
  end

  // ---------------- bus responder (unbuffered instance), latency 2 ----------------
  logic [31:0] u1_word = '0;
  initial begin : u1_responder
    int cnt;
    cnt = 0;
    forever begin
      @(posedge clk); #1;
      if (u1_ack) u1_ack = 1'b0;
      else if (u1_req) begin
        cnt++;
        if (cnt == 2) begin
          cnt = 0;
          u1_ack = 1'b1;
          if (u1_we) u1_word = merge(u1_word, u1_wstrb, u1_mwdata);
          else       u1_mrdata = u1_word;
        end
      end
    end
  end

  // ---------------- load-data monitor ----------------
  logic [31:0] exp_q[$];
  bit mon_en = 1'b1;

  initial begin : monitor
    bit          acc_prev;
    logic [31:0] held;
    acc_prev = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        acc_prev = 1'b0;
        continue;
      end
      if (acc_prev) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL load_data: got 0x%08h with no load outstanding", data_sram_rdata);
        end else begin
          held = exp_q.pop_front();
          chk("load_data", data_sram_rdata, held);
        end
      end else begin
        chk("rdata_held", data_sram_rdata, held);
      end
      acc_prev = data_sram_en && !stallreq_for_mem && (data_sram_wen == 4'b0);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic do_req(input logic [3:0] wen, input logic [31:0] addr,
                        input logic [31:0] wdata, output int stalls);
    bit done;
    done = 1'b0;
    stalls = 0;
    data_sram_en = 1'b1; data_sram_wen = wen;
    data_sram_addr = addr; data_sram_wdata = wdata;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (stallreq_for_mem) stalls++;
      else begin
        done = 1'b1;
        if (wen != 4'b0) arch_mem[widx(addr)] = merge(arch_rd(widx(addr)), wen, wdata);
        else             exp_q.push_back(arch_rd(widx(addr)));
      end
      @(posedge clk); #1;
    end
    if (!done) fail_now("req_accept");
    data_sram_en = 1'b0; data_sram_wen = '0;
  endtask

  task automatic u1_do(input logic [3:0] wen, input logic [31:0] addr,
                       input logic [31:0] wdata, output int stalls);
    bit done;
    done = 1'b0;
    stalls = 0;
    u1_en = 1'b1; u1_wen = wen; u1_addr = addr; u1_wdata = wdata;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (u1_stall) stalls++;
      else done = 1'b1;
      @(posedge clk); #1;
    end
    if (!done) fail_now("u1_accept");
    u1_en = 1'b0; u1_wen = '0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(posedge clk); #1;
      if (!wbuf_busy && !mem_req) ok = 1'b1;
    end
    if (!ok) fail_now("wait_idle");
  endtask

  task automatic chk_txn(input string name, input int idx, input logic we, input logic [31:0] addr);
    if (bus_log.size() > idx) begin
      chk({name, "_we"}, {31'b0, bus_log[idx].we}, {31'b0, we});
      chk({name, "_addr"}, bus_log[idx].addr, addr);
    end else begin
      checks++; errors++;
      $display("FAIL %s: bus transaction %0d missing, got %0d transactions", name, idx, bus_log.size());
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  logic [3:0] wens [7] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};

  initial begin
    int s, s2;
    logic [31:0] d1, d2, a;
    #2 resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    // reset state
    chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
    chk("rst_stall", {31'b0, stallreq_for_mem}, 32'd0);
    chk("rst_wbuf_busy", {31'b0, wbuf_busy}, 32'd0);
    chk("rst_rdata", data_sram_rdata, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_ctrl", {27'b0, mem_we, mem_wstrb}, 32'd0);
    resetn = 1'b1;
    @(posedge clk); #1;

    // load with 3-cycle ack latency
    bus_mem[widx(32'h1004)]  = 32'hDEAD_BEEF;
    arch_mem[widx(32'h1004)] = 32'hDEAD_BEEF;
    bus_log.delete();
    fixed_lat = 3;
    do_req(4'b0000, 32'h0000_1004, 32'h0, s);
    chk("t1_load_stall", s, 32'd4);
    chk_txn("t1_read", 0, 1'b0, 32'h0000_1004);
    repeat (3) begin @(posedge clk); #1; end
    chk("t1_rdata_held", data_sram_rdata, 32'hDEAD_BEEF);

    // single buffered store
    bus_log.delete();
    fixed_lat = 2;
    do_req(4'b0010, 32'h0000_2001, 32'h0000_AB00, s);
    chk("t2_store_stall", s, 32'd0);
    chk("t2_wbuf_busy", {31'b0, wbuf_busy}, 32'd1);
    wait_idle();
    chk_txn("t2_drain", 0, 1'b1, 32'h0000_2000);
    if (bus_log.size() > 0) chk("t2_wstrb", {28'b0, bus_log[0].wstrb}, 32'h2);

    // back-to-back stores
    bus_log.delete();
    d1 = $urandom; d2 = $urandom;
    do_req(4'b1111, 32'h0000_2100, d1, s);
    do_req(4'b1111, 32'h0000_2104, d2, s2);
    chk("t3_first_stall", s, 32'd0);
    chk("t3_second_stall", s2, 32'd3);
    wait_idle();
    chk_txn("t3_first", 0, 1'b1, 32'h0000_2100);
    chk_txn("t3_second", 1, 1'b1, 32'h0000_2104);

    // load to a word with a pending store: drain first
    bus_log.delete();
    do_req(4'b1111, 32'h0000_3000, $urandom, s);
    do_req(4'b0000, 32'h0000_3002, 32'h0, s2);
    chk("t4a_load_stall", s2, 32'd6);
    wait_idle();
    chk_txn("t4a_drain", 0, 1'b1, 32'h0000_3000);
    chk_txn("t4a_read", 1, 1'b0, 32'h0000_3000);

    // load to another word: read goes ahead of the drain
    bus_log.delete();
    do_req(4'b1111, 32'h0000_4000, $urandom, s);
    do_req(4'b0000, 32'h0000_5000, 32'h0, s2);
    chk("t4b_load_stall", s2, 32'd3);
    wait_idle();
    chk_txn("t4b_read", 0, 1'b0, 32'h0000_5000);
    chk_txn("t4b_drain", 1, 1'b1, 32'h0000_4000);

    // unbuffered instance
    u1_do(4'b0110, 32'h0000_6000, 32'h1234_5678, s);
    chk("u1_store_stall", s, 32'd2);
    chk("u1_busy_after", {31'b0, u1_busy}, 32'd0);
    chk("u1_mem_word", u1_word, 32'h0034_5600);
    u1_do(4'b0000, 32'h0000_6000, 32'h0, s);
    chk("u1_load_stall", s, 32'd3);
    chk("u1_load_data", u1_rdata, 32'h0034_5600);

    // randomized traffic on a small address window
    fixed_lat = 0;
    for (int n = 0; n < 250; n++) begin
      int r;
      r = int'($urandom_range(0, 9));
      a = 32'h0000_0400 + 32'($urandom_range(0, 7) << 2) + 32'($urandom_range(0, 3));
      if (r < 4)      do_req(4'b0000, a, 32'h0, s);
      else if (r < 8) do_req(wens[$urandom_range(0, 6)], a, $urandom, s);
      else repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
    end
    wait_idle();
    for (int w = 32'h100; w < 32'h108; w++) chk("final_mem", bus_rd(w), arch_rd(w));
    repeat (2) begin @(posedge clk); #1; end

    // reset in the middle of a read with a store still buffered
    mon_en = 1'b0;
    resp_en = 1'b0;
    do_req(4'b1111, 32'h0000_7100, 32'hCAFE_F00D, s);
    data_sram_en = 1'b1; data_sram_wen = 4'b0000; data_sram_addr = 32'h0000_7000;
    repeat (2) begin @(posedge clk); #1; end
    chk("t6_pre_mem_req", {31'b0, mem_req}, 32'd1);
    #2 resetn = 1'b0;
    #1;
    chk("t6_rst_mem_req", {31'b0, mem_req}, 32'd0);
    chk("t6_rst_stall", {31'b0, stallreq_for_mem}, 32'd0);
    chk("t6_rst_wbuf_busy", {31'b0, wbuf_busy}, 32'd0);
    chk("t6_rst_rdata", data_sram_rdata, 32'd0);
    data_sram_en = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    inject_ack = 1'b1;
    @(negedge clk);
    inject_ack = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("t6_stray_mem_req", {31'b0, mem_req}, 32'd0);
      chk("t6_stray_busy", {31'b0, wbuf_busy}, 32'd0);
      chk("t6_stray_rdata", data_sram_rdata, 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
